// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into 32-bit words
// tagged with sequential byte addresses, with one registered output stage and a bounded run.
module instr_encoder #(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter int unsigned          DEPTH     = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_type,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       count,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [16:0] DEPTH_X = 17'(DEPTH);

   state_t            state, state_nx;
   logic              valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       count_q;
   logic              err_q;

   logic [31:0]       enc;
   logic              misaligned;
   logic              accept;
   logic              out_hs;
   logic [16:0]       count_x;

   // Field packing for each supported instruction class
   always_comb begin
      enc = '0;
      unique case (in_type)
         3'd0: enc = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         3'd1: begin
            if (in_funct3 == 3'b101)
               enc = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            else
               enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         end
         3'd2: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
         3'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
         3'd4: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'b1100011};
         3'd5: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
         3'd6: enc = {in_imm[31:12], in_rd, 7'b0110111};
         3'd7: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         default: enc = '0;
      endcase
   end

   assign misaligned = ((in_type == 3'd4) || (in_type == 3'd5)) && in_imm[0];
   assign count_x    = {1'b0, count_q};
   assign out_hs     = valid_q && out_ready;

   // A start pulse holds off acceptance so no word is taken and then discarded
   always_comb begin
      in_ready = 1'b0;
      if (state == RUN && !start)
         in_ready = (!valid_q || out_ready) && ((count_x + 17'(valid_q)) < DEPTH_X);
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = RUN;
      end else begin
         unique case (state)
            IDLE: state_nx = IDLE;
            RUN:  if (out_hs && (count_x + 17'd1 >= DEPTH_X)) state_nx = FIN;
            FIN:  state_nx = FIN;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else if (start) begin
         valid_q <= 1'b0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (out_hs) begin
            addr_q <= addr_q + ADDR_W'(4);
            if (count_x < DEPTH_X) count_q <= count_q + 16'd1;
         end
         if (accept && misaligned)
            err_q <= 1'b1;
         if (accept && !misaligned) begin
            valid_q <= 1'b1;
            instr_q <= enc;
         end else if (out_hs) begin
            valid_q <= 1'b0;
         end
      end
   end

   // The address register always names the word currently held in the output stage
   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign count     = count_q;
   assign done      = (state == FIN);
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus stall, misalignment,
// start-discard and bounded-run sequences.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_type = '0, in_funct3 = '0;
   logic        in_alt = 1'b0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, done_a, err_a;
   logic [31:0] out_instr_a, out_addr_a;
   logic [15:0] count_a;
   logic        in_ready_b, out_valid_b, done_b, err_b;
   logic [31:0] out_instr_b, out_addr_b;
   logic [15:0] count_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(256)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_type(in_type), .in_funct3(in_funct3), .in_alt(in_alt),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_instr(out_instr_a), .out_addr(out_addr_a),
      .count(count_a), .done(done_a), .err(err_a)
   );

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h100), .DEPTH(4)) dut_d (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_type(in_type), .in_funct3(in_funct3), .in_alt(in_alt),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_instr(out_instr_b), .out_addr(out_addr_b),
      .count(count_b), .done(done_b), .err(err_b)
   );

   typedef struct {
      logic [2:0]  typ;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      in_type = v.typ; in_funct3 = v.f3; in_alt = v.alt;
      in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse_a();
      start_a = 1'b1; step(); start_a = 1'b0;
   endtask

   task automatic pulse_b();
      start_b = 1'b1; step(); start_b = 1'b0;
   endtask

   initial begin
      int accepts;
      int cyc;
      vec_t a, b;
      //            typ   f3    alt  rd  rs1 rs2 imm            expected
      vecs[0] = '{3'd1, 3'd0, 1'b0, 1,  0,  0, 32'd5,         32'h00500093}; // addi x1,x0,5
      vecs[1] = '{3'd0, 3'd0, 1'b1, 3,  1,  2, 32'd0,         32'h402081B3}; // sub x3,x1,x2
      vecs[2] = '{3'd3, 3'd2, 1'b0, 0,  1,  2, 32'd8,         32'h0020A423}; // sw x2,8(x1)
      vecs[3] = '{3'd4, 3'd0, 1'b0, 0,  1,  2, 32'hFFFFFFFC,  32'hFE208EE3}; // beq -4
      vecs[4] = '{3'd5, 3'd0, 1'b0, 1,  0,  0, 32'd8,         32'h008000EF}; // jal x1,8
      vecs[5] = '{3'd6, 3'd0, 1'b0, 5,  0,  0, 32'h12345FFF,  32'h123452B7}; // lui, low imm ignored
      vecs[6] = '{3'd1, 3'd5, 1'b1, 2,  3,  0, 32'hFFFFFFE7,  32'h4071D113}; // srai x2,x3,7
      vecs[7] = '{3'd7, 3'd3, 1'b0, 1,  5,  0, 32'h10,        32'h010280E7}; // jalr, f3 forced 0
      vecs[8] = '{3'd2, 3'd2, 1'b0, 4,  2,  0, 32'hFFFFFFFF,  32'hFFF12203}; // lw x4,-1(x2)

      // Reset state, including in_ready low in IDLE with in_valid asserted
      in_valid = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_instr", out_instr_a, 32'h0);
      check("rst_out_addr", out_addr_a, 32'h0);
      check("rst_count", 32'(count_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd0);
      check("rst_out_addr_d", out_addr_b, 32'h100);
      step(); rst_n = 1'b1; step();
      check("idle_in_ready", 32'(in_ready_a), 32'd0);
      in_valid = 1'b0;

      // Back-to-back table stream with out_ready held high
      out_ready = 1'b1;
      pulse_a();
      for (int i = 0; i < 9; i++) begin
         apply(vecs[i]); in_valid = 1'b1;
         @(negedge clk);
         check($sformatf("in_ready[%0d]", i), 32'(in_ready_a), 32'd1);
         if (i > 0) begin
            check($sformatf("valid[%0d]", i-1), 32'(out_valid_a), 32'd1);
            check($sformatf("instr[%0d]", i-1), out_instr_a, vecs[i-1].exp);
            check($sformatf("addr[%0d]", i-1), out_addr_a, 32'(4*(i-1)));
         end
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("instr[8]", out_instr_a, vecs[8].exp);
      check("addr[8]", out_addr_a, 32'h20);
      step();
      @(negedge clk);
      check("drain_valid", 32'(out_valid_a), 32'd0);
      check("stream_count", 32'(count_a), 32'd9);
      check("stream_addr", out_addr_a, 32'h24);

      // Backpressure: word held, input waits, nothing lost
      pulse_a();
      a = vecs[0]; b = vecs[5];
      out_ready = 1'b0;
      apply(a); in_valid = 1'b1; step();
      apply(b);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall_in_ready[%0d]", k), 32'(in_ready_a), 32'd0);
         check($sformatf("stall_valid[%0d]", k), 32'(out_valid_a), 32'd1);
         check($sformatf("stall_instr[%0d]", k), out_instr_a, a.exp);
         check($sformatf("stall_addr[%0d]", k), out_addr_a, 32'h0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(in_ready_a), 32'd1);
      step(); in_valid = 1'b0;
      @(negedge clk);
      check("release_instr", out_instr_a, b.exp);
      check("release_addr", out_addr_a, 32'h4);
      step();
      @(negedge clk);
      check("release_count", 32'(count_a), 32'd2);

      // Misaligned branch and jump: consumed, no word, sticky err
      apply('{3'd4, 3'd0, 1'b0, 0, 1, 2, 32'd3, 32'h0}); in_valid = 1'b1; step();
      in_valid = 1'b0;
      @(negedge clk);
      check("mis_valid", 32'(out_valid_a), 32'd0);
      check("mis_err", 32'(err_a), 32'd1);
      check("mis_count", 32'(count_a), 32'd2);
      check("mis_addr", out_addr_a, 32'h8);
      apply(vecs[0]); in_valid = 1'b1; step(); in_valid = 1'b0;
      @(negedge clk);
      check("err_sticky", 32'(err_a), 32'd1);
      check("post_mis_addr", out_addr_a, 32'h8);
      step();
      apply('{3'd5, 3'd0, 1'b0, 1, 0, 0, 32'd9, 32'h0}); in_valid = 1'b1; step(); in_valid = 1'b0;
      @(negedge clk);
      check("jal_mis_valid", 32'(out_valid_a), 32'd0);
      check("jal_mis_count", 32'(count_a), 32'd3);
      pulse_a();
      @(negedge clk);
      check("start_err_clr", 32'(err_a), 32'd0);
      check("start_addr", out_addr_a, 32'h0);
      check("start_count", 32'(count_a), 32'd0);

      // Start discards a pending word
      out_ready = 1'b0;
      apply(vecs[1]); in_valid = 1'b1; step(); in_valid = 1'b0;
      pulse_a();
      @(negedge clk);
      check("discard_valid", 32'(out_valid_a), 32'd0);
      check("discard_addr", out_addr_a, 32'h0);
      out_ready = 1'b1;

      // Bounded run on the DEPTH=4 instance
      apply(vecs[0]);
      pulse_b();
      in_valid = 1'b1;
      accepts = 0;
      cyc = 0;
      while (!done_b && cyc < 20) begin
         @(negedge clk);
         if (in_ready_b) accepts++;
         if (count_b == 16'd3 && out_valid_b) begin
            check("d_last_in_ready", 32'(in_ready_b), 32'd0);
            check("d_last_addr", out_addr_b, 32'h10C);
         end
         step();
         cyc++;
      end
      @(negedge clk);
      check("d_done_in_time", 32'(cyc < 20), 32'd1);
      check("d_accepts", 32'(accepts), 32'd4);
      check("d_done", 32'(done_b), 32'd1);
      check("d_count", 32'(count_b), 32'd4);
      check("d_in_ready", 32'(in_ready_b), 32'd0);
      check("d_valid", 32'(out_valid_b), 32'd0);
      step(); step();
      @(negedge clk);
      check("d_hold_in_ready", 32'(in_ready_b), 32'd0);
      check("d_hold_count", 32'(count_b), 32'd4);
      pulse_b();
      @(negedge clk);
      check("d_restart_done", 32'(done_b), 32'd0);
      check("d_restart_count", 32'(count_b), 32'd0);
      check("d_restart_in_ready", 32'(in_ready_b), 32'd1);
      check("d_restart_addr", out_addr_b, 32'h100);
      in_valid = 1'b0;

      // Asynchronous reset mid-run drops the pending word at once
      out_ready = 1'b0;
      pulse_a();
      apply(vecs[2]); in_valid = 1'b1; step(); in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid_a), 32'd0);
      check("async_rst_instr", out_instr_a, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
